// File: rtl/fsm_sup_pkg.sv
// rtl/fsm_sup_pkg.sv - shared types, default timeouts and helpers for the job supervisor
package fsm_sup_pkg;

    // Supervisor state; the encoding is visible on sup_state for debug.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_ABORT     = 3'd6,
        ST_RECOVER   = 3'd7
    } sup_state_e;

    // Per-job result returned on rsp_status.
    typedef enum logic [1:0] {
        RSP_OK          = 2'd0,
        RSP_ACK_TIMEOUT = 2'd1,
        RSP_CTRL_ERROR  = 2'd2,
        RSP_STUCK       = 2'd3
    } rsp_status_e;

    localparam int DEF_LEN_W           = 8;
    localparam int DEF_ACK_TIMEOUT     = 8;
    localparam int DEF_IDLE_TIMEOUT    = 8;
    localparam int DEF_RECOVER_TIMEOUT = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The first failure cause of a job is kept; STUCK always overrides,
    // because a controller that will not settle is the more severe fact.
    function automatic rsp_status_e merge_status(input rsp_status_e cur,
                                                 input rsp_status_e nxt);
        if (cur == RSP_OK || nxt == RSP_STUCK) begin
            return nxt;
        end
        return cur;
    endfunction

endpackage

// File: rtl/fsm_job_supervisor.sv
// rtl/fsm_job_supervisor.sv - job supervisor sequencing start/done/fault for the controller FSM
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   job_valid/job_ready    upstream job handshake, job_len sampled on accept
//   rsp_valid/rsp_ready    per-job result handshake, rsp_status holds the result
//   ctrl_start/done/fault  registered one-cycle pulses to the controller
//   ctrl_busy/ctrl_error   controller status, same clock domain
//   locked                 sticky, controller failed to recover (cleared by reset)
//   err_count              saturating count of non-OK results
//   sup_state              current state encoding
module fsm_job_supervisor
    import fsm_sup_pkg::*;
#(
    parameter int LEN_W           = DEF_LEN_W,
    parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
    parameter int IDLE_TIMEOUT    = DEF_IDLE_TIMEOUT,
    parameter int RECOVER_TIMEOUT = DEF_RECOVER_TIMEOUT,
    parameter int TMR_W           = $clog2(max3(ACK_TIMEOUT, IDLE_TIMEOUT, RECOVER_TIMEOUT)) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic             ctrl_start,
    output logic             ctrl_done,
    output logic             ctrl_fault,
    input  logic             ctrl_busy,
    input  logic             ctrl_error,
    output logic             locked,
    output logic [7:0]       err_count,
    output logic [2:0]       sup_state
);

    sup_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    rsp_status_e       status_q, status_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              locked_q, locked_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              ctrl_start_q, ctrl_start_d;
    logic              ctrl_done_q, ctrl_done_d;
    logic              ctrl_fault_q, ctrl_fault_d;
    logic              post;

    assign job_ready  = (state_q == ST_IDLE) && !rsp_valid_q && !locked_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = status_q;
    assign locked     = locked_q;
    assign err_count  = err_count_q;
    assign sup_state  = state_q;
    assign ctrl_start = ctrl_start_q;
    assign ctrl_done  = ctrl_done_q;
    assign ctrl_fault = ctrl_fault_q;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        rsp_valid_d = rsp_valid_q;
        locked_d    = locked_q;
        err_count_d = err_count_q;
        post        = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready) begin
                    cnt_d    = job_len;
                    status_d = RSP_OK;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tmr_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (ctrl_error) begin
                    status_d = merge_status(status_q, RSP_CTRL_ERROR);
                    tmr_d    = '0;
                    state_d  = ST_RECOVER;
                end else if (ctrl_busy) begin
                    state_d = ST_RUN;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    status_d = merge_status(status_q, RSP_ACK_TIMEOUT);
                    state_d  = ST_ABORT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (ctrl_error) begin
                    status_d = merge_status(status_q, RSP_CTRL_ERROR);
                    tmr_d    = '0;
                    state_d  = ST_RECOVER;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_DONE: begin
                tmr_d   = '0;
                state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (ctrl_error) begin
                    status_d = merge_status(status_q, RSP_CTRL_ERROR);
                    tmr_d    = '0;
                    state_d  = ST_RECOVER;
                end else if (!ctrl_busy) begin
                    post = 1'b1;
                end else if (tmr_q == TMR_W'(IDLE_TIMEOUT - 1)) begin
                    status_d = merge_status(status_q, RSP_STUCK);
                    state_d  = ST_ABORT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_ABORT: begin
                tmr_d   = '0;
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                // Recovery is checked before the timeout so a controller that
                // settles on the last allowed cycle is not declared stuck.
                if (!ctrl_error && !ctrl_busy) begin
                    post = 1'b1;
                end else if (tmr_q == TMR_W'(RECOVER_TIMEOUT - 1)) begin
                    status_d = merge_status(status_q, RSP_STUCK);
                    locked_d = 1'b1;
                    post     = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (post) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            if (status_d != RSP_OK && err_count_q != 8'hff) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        // Pulses follow the next state so they are registered yet line up
        // with the cycle the supervisor spends in START/DONE/ABORT. Those
        // states are never adjacent, so the pulses can never touch.
        ctrl_start_d = (state_d == ST_START);
        ctrl_done_d  = (state_d == ST_DONE);
        ctrl_fault_d = (state_d == ST_ABORT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            cnt_q        <= '0;
            status_q     <= RSP_OK;
            rsp_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
            err_count_q  <= 8'd0;
            ctrl_start_q <= 1'b0;
            ctrl_done_q  <= 1'b0;
            ctrl_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            cnt_q        <= cnt_d;
            status_q     <= status_d;
            rsp_valid_q  <= rsp_valid_d;
            locked_q     <= locked_d;
            err_count_q  <= err_count_d;
            ctrl_start_q <= ctrl_start_d;
            ctrl_done_q  <= ctrl_done_d;
            ctrl_fault_q <= ctrl_fault_d;
        end
    end

endmodule
